sa_controller: RTL and testbench

SA_CONTROLLER -- requirements
Module: sa_controller

---
 rtl/sa_controller.sv | 151 +++++++++++++++
 tb/tb_sa_controller.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sa_controller.sv
// Sequencer for a weight-stationary systolic array tile: load weights, shift them into the PEs,
// load activations, compute, drain and read out. Optional macro SA_CTRL_WEIGHT_REUSE_EN adds reuse_w.
module sa_controller #(
  parameter int ARRAY_W = 4,
  parameter int CNT_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             w_valid,
  input  logic             a_valid,
`ifdef SA_CTRL_WEIGHT_REUSE_EN
  input  logic             reuse_w,
`endif
  output logic             weight_buffer_load_en,
  output logic             weight_buffer_out_en,
  output logic             write_weight_en,
  output logic             input_buffer_load_en,
  output logic             input_buffer_out_en,
  output logic             output_buffer_load_en,
  output logic             output_buffer_out_en,
  output logic             busy,
  output logic             done,
  output logic             res_valid,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD_W  = 3'd1,
    S_SHIFT_W = 3'd2,
    S_LOAD_A  = 3'd3,
    S_COMPUTE = 3'd4,
    S_DRAIN   = 3'd5,
    S_READOUT = 3'd6,
    S_DONE    = 3'd7
  } state_e;

  // Terminal counts are N-1 because the counter starts at zero on entry to each phase.
  localparam logic [CNT_W-1:0] LAST_ROW     = CNT_W'(ARRAY_W - 1);
  localparam logic [CNT_W-1:0] LAST_COMPUTE = CNT_W'(3 * ARRAY_W - 3);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             skip_w;
`ifdef SA_CTRL_WEIGHT_REUSE_EN
  assign skip_w = reuse_w;
`else
  assign skip_w = 1'b0;
`endif

  // Per-phase qualifier, terminal count and successor feed one shared counting rule.
  logic             qual;
  logic [CNT_W-1:0] last;
  state_e           nxt;

  always_comb begin
    // NOTE: every signal gets a default up front so no path through the case can infer a latch.
    qual = 1'b1;
    last = LAST_ROW;
    nxt  = S_IDLE;
    unique case (state_q)
      S_LOAD_W:  begin qual = w_valid; nxt = S_SHIFT_W; end
      S_SHIFT_W: nxt = S_LOAD_A;
      S_LOAD_A:  begin qual = a_valid; nxt = S_COMPUTE; end
      S_COMPUTE: begin last = LAST_COMPUTE; nxt = S_DRAIN; end
      S_DRAIN:   nxt = S_READOUT;
      S_READOUT: nxt = S_DONE;
      default:   nxt = S_IDLE;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (abort) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d = skip_w ? S_LOAD_A : S_LOAD_W;
            cnt_d   = '0;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
        default: begin
          // A stalled handshake leaves both state and counter untouched.
          if (qual) begin
            if (cnt_q == last) begin
              state_d = nxt;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs decode the registered state, so reset clears them without waiting for an edge.
  always_comb begin
    weight_buffer_load_en = 1'b0;
    weight_buffer_out_en  = 1'b0;
    write_weight_en       = 1'b0;
    input_buffer_load_en  = 1'b0;
    input_buffer_out_en   = 1'b0;
    output_buffer_load_en = 1'b0;
    output_buffer_out_en  = 1'b0;
    res_valid             = 1'b0;
    done                  = 1'b0;
    busy                  = (state_q != S_IDLE);
    unique case (state_q)
      S_LOAD_W:  weight_buffer_load_en = w_valid;
      S_SHIFT_W: begin
        weight_buffer_out_en = 1'b1;
        write_weight_en      = 1'b1;
      end
      S_LOAD_A:  input_buffer_load_en  = a_valid;
      S_COMPUTE: input_buffer_out_en   = 1'b1;
      S_DRAIN:   output_buffer_load_en = 1'b1;
      S_READOUT: begin
        output_buffer_out_en = 1'b1;
        res_valid            = 1'b1;
      end
      S_DONE:    done = 1'b1;
      default:   ;
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_sa_controller.sv
// Self-checking bench for sa_controller: vector table, directed phase-timing sequences and
// randomized traffic compared each cycle against a phase-length reference model.
module tb_sa_controller;

  localparam int W = 4;
`ifdef SA_CTRL_WEIGHT_REUSE_EN
  localparam bit REUSE_BUILD = 1'b1;
`else
  localparam bit REUSE_BUILD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, start, abort, w_valid, a_valid, reuse_w;
  logic wbl, wbo, ww, ibl, ibo, obl, obo, busy, done, res_valid;
  logic [2:0] state;

  int n_checks = 0;
  int n_fail   = 0;

  sa_controller #(.ARRAY_W(W), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .w_valid(w_valid), .a_valid(a_valid),
`ifdef SA_CTRL_WEIGHT_REUSE_EN
    .reuse_w(reuse_w),
`endif
    .weight_buffer_load_en(wbl), .weight_buffer_out_en(wbo), .write_weight_en(ww),
    .input_buffer_load_en(ibl), .input_buffer_out_en(ibo),
    .output_buffer_load_en(obl), .output_buffer_out_en(obo),
    .busy(busy), .done(done), .res_valid(res_valid), .state(state)
  );

  always #5 clk = ~clk;

  // Packed view: {state[2:0], wbl, wbo, ww, ibl, ibo, obl, obo, busy, done, res_valid}
  function automatic logic [12:0] get_obs();
    return {state, wbl, wbo, ww, ibl, ibo, obl, obo, busy, done, res_valid};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a phase index plus accepted-cycle progress against a table of phase lengths.
  int m_phase = 0;
  int m_k     = 0;

  function automatic int phase_len(input int p);
    case (p)
      4:       return 3 * W - 2;
      7:       return 1;
      default: return W;
    endcase
  endfunction

  function automatic logic [12:0] model_out(input int p, input logic wv, input logic av);
    logic [2:0] s;
    s = 3'(p);
    return {s, (p == 1) & wv, p == 2, p == 2, (p == 3) & av, p == 4, p == 5, p == 6,
            p != 0, p == 7, p == 6};
  endfunction

  task automatic model_step(input logic s, input logic ab, input logic wv, input logic av);
    bit q;
    if (ab) begin
      m_phase = 0; m_k = 0;
    end else if (m_phase == 0) begin
      if (s) begin
        m_phase = (REUSE_BUILD && reuse_w) ? 3 : 1;
        m_k = 0;
      end
    end else begin
      q = (m_phase == 1) ? wv : (m_phase == 3) ? av : 1'b1;
      if (q) m_k++;
      if (m_k == phase_len(m_phase)) begin
        m_phase = (m_phase == 7) ? 0 : m_phase + 1;
        m_k = 0;
      end
    end
  endtask

  // One clock: drive after the edge, compare at the falling edge, advance the model at the rising edge.
  task automatic do_cycle(input logic s, input logic ab, input logic wv, input logic av,
                          output logic [12:0] o);
    start = s; abort = ab; w_valid = wv; a_valid = av;
    @(negedge clk);
    o = get_obs();
    check("model", 32'(o), 32'(model_out(m_phase, wv, av)));
    @(posedge clk);
    model_step(s, ab, wv, av);
    #1;
  endtask

  int  hist[8];
  int  busy_cnt;
  int  ww_cnt;
  bit  timed_out;

  // Issue a start, then run with both valids high until done is observed or the budget expires.
  task automatic run_full(input int bound);
    logic [12:0] o;
    foreach (hist[i]) hist[i] = 0;
    busy_cnt = 0; ww_cnt = 0; timed_out = 1'b1;
    do_cycle(1'b1, 1'b0, 1'b1, 1'b1, o);
    for (int i = 0; i < bound; i++) begin
      do_cycle(1'b0, 1'b0, 1'b1, 1'b1, o);
      hist[o[12:10]]++;
      if (o[2]) busy_cnt++;
      if (o[7]) ww_cnt++;
      if (o[1]) begin timed_out = 1'b0; break; end
    end
    check("run_timeout", 32'(timed_out), 0);
  endtask

  typedef struct {
    logic s, ab, wv, av;
    logic [2:0] exp_state;
    logic exp_busy, exp_wbl;
  } vec_t;

  initial begin
    vec_t vecs[14];
    logic [12:0] o;
    int lw_cycles, mirror_err, cseen, idle_len;
    bit done_seen, ab;

    vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 3'd1, 1'b1, 1'b1};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 3'd1, 1'b1, 1'b1};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 3'd1, 1'b1, 1'b1};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 3'd1, 1'b1, 1'b1};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd2, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 1'b1, 1'b0};
    vecs[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0};

    rst = 1'b1; start = 1'b0; abort = 1'b0; w_valid = 1'b0; a_valid = 1'b0; reuse_w = 1'b0;
    #12;
    check("reset_outputs", 32'(get_obs()), 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Vector table: stalls, ignored start, abort priority over start.
    for (int i = 0; i < 14; i++) begin
      do_cycle(vecs[i].s, vecs[i].ab, vecs[i].wv, vecs[i].av, o);
      check($sformatf("vec%0d", i), {29'd0, o[12:10]} << 2 | 32'({o[2], o[9]}),
            {29'd0, vecs[i].exp_state} << 2 | 32'({vecs[i].exp_busy, vecs[i].exp_wbl}));
    end

    // Full tile with no stalls: phase lengths and busy window.
    run_full(100);
    check("len_load_w",  hist[1], W);
    check("len_shift_w", hist[2], W);
    check("len_load_a",  hist[3], W);
    check("len_compute", hist[4], 3 * W - 2);
    check("len_drain",   hist[5], W);
    check("len_readout", hist[6], W);
    check("len_done",    hist[7], 1);
    check("busy_cycles", busy_cnt, 31);

    // Toggling w_valid: load enable mirrors it and LOAD_W stretches to 7 cycles.
    do_cycle(1'b0, 1'b0, 1'b0, 1'b0, o);
    do_cycle(1'b1, 1'b0, 1'b0, 1'b0, o);
    lw_cycles = 0; mirror_err = 0;
    for (int i = 0; i < 20 && m_phase == 1; i++) begin
      do_cycle(1'b0, 1'b0, (i % 2) == 0, 1'b0, o);
      lw_cycles++;
      if (o[9] !== ((i % 2) == 0)) mirror_err++;
    end
    check("toggle_load_w_len", lw_cycles, 7);
    check("toggle_mirror", mirror_err, 0);
    do_cycle(1'b0, 1'b1, 1'b0, 1'b0, o);

    // Abort on the third COMPUTE cycle, then a clean full run.
    do_cycle(1'b1, 1'b0, 1'b1, 1'b1, o);
    cseen = 0; done_seen = 1'b0; ab = 1'b0;
    for (int i = 0; i < 60 && !ab; i++) begin
      ab = (m_phase == 4) && (cseen == 2);
      if (m_phase == 4) cseen++;
      do_cycle(1'b0, ab, 1'b1, 1'b1, o);
      if (o[1]) done_seen = 1'b1;
    end
    check("abort_reached", 32'(ab), 1);
    do_cycle(1'b0, 1'b0, 1'b1, 1'b1, o);
    check("abort_state", 32'(o[12:10]), 0);
    check("abort_busy_done", 32'({o[2], o[1], done_seen}), 0);
    run_full(100);
    check("after_abort_busy", busy_cnt, 31);

    // Asynchronous reset in the middle of DRAIN clears outputs before the next edge.
    do_cycle(1'b1, 1'b0, 1'b1, 1'b1, o);
    for (int i = 0; i < 60 && !(m_phase == 5 && m_k == 1); i++) do_cycle(1'b0, 1'b0, 1'b1, 1'b1, o);
    check("drain_reached", m_phase, 5);
    #2 rst = 1'b1;
    #1 check("async_rst_outputs", 32'(get_obs()), 0);
    @(negedge clk); rst = 1'b0;
    m_phase = 0; m_k = 0;
    @(posedge clk); #1;
    run_full(100);
    check("after_rst_busy", busy_cnt, 31);

    // Start held high: one IDLE cycle after done, then the next operation begins.
    done_seen = 1'b0;
    for (int i = 0; i < 80 && !done_seen; i++) begin
      do_cycle(1'b1, 1'b0, 1'b1, 1'b1, o);
      done_seen = o[1];
    end
    check("held_done_seen", 32'(done_seen), 1);
    do_cycle(1'b1, 1'b0, 1'b1, 1'b1, o);
    check("held_idle_after_done", 32'(o[12:10]), 0);
    idle_len = 0;
    do_cycle(1'b1, 1'b0, 1'b1, 1'b1, o);
    if (o[12:10] == 3'd0) idle_len++;
    check("held_restart", 32'(o[12:10]), 1);
    check("held_single_idle", idle_len, 0);
    do_cycle(1'b0, 1'b1, 1'b0, 1'b0, o);

`ifdef SA_CTRL_WEIGHT_REUSE_EN
    reuse_w = 1'b1;
    run_full(100);
    reuse_w = 1'b0;
    check("reuse_busy", busy_cnt, 23);
    check("reuse_no_write_weight", ww_cnt, 0);
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      reuse_w = 1'($urandom_range(0, 1));
      do_cycle($urandom_range(0, 3) == 0, $urandom_range(0, 39) == 0,
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), o);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
